// File: rtl/dag_pkg.sv
// -----------------------------------------------------------------------------
// dag_pkg
// Shared definitions for the dag_mod data address generator.
//   - SEL_* : 3-bit register-select codes presented on cfg_sel.
//   - AW_DEF: default address/register width.
//   - bit_rev(): mirrors the low w bits of a vector (used for reverse-carry
//     addressing when DAG_BITREV_EN is defined).
// -----------------------------------------------------------------------------
package dag_pkg;

   localparam int AW_DEF = 16;

   localparam logic [2:0] SEL_I    = 3'd0;
   localparam logic [2:0] SEL_B    = 3'd1;
   localparam logic [2:0] SEL_L    = 3'd2;
   localparam logic [2:0] SEL_M    = 3'd3;
   localparam logic [2:0] SEL_MODE = 3'd4;

   // Mirror bits [w-1:0] of v; bits at and above w in the result are zero.
   // A fixed 64-bit container keeps the function usable for any AW <= 64.
   function automatic logic [63:0] bit_rev(input logic [63:0] v, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) begin
            r[w-1-i] = v[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dag_channel.sv
// -----------------------------------------------------------------------------
// dag_channel
// One address-generator channel: I/B/L/M (and MODE) registers, post-modify
// arithmetic with single-correction circular wrap, and the registered wrap
// pulse.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   wr_i/b/l/m     decoded register write strobes for this channel
//   wr_mode        MODE write strobe (only present with DAG_BITREV_EN)
//   wd             write data (M is two's complement)
//   step           post-modify request
//   idx            current index register (pre-modify while step is high)
//   wrap           high the cycle after a modulo-corrected step
//
// Optional feature macro: DAG_BITREV_EN (reverse-carry addressing).
// -----------------------------------------------------------------------------
module dag_channel
   import dag_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_i,
   input  logic          wr_b,
   input  logic          wr_l,
   input  logic          wr_m,
`ifdef DAG_BITREV_EN
   input  logic          wr_mode,
`endif
   input  logic [AW-1:0] wd,
   input  logic          step,
   output logic [AW-1:0] idx,
   output logic          wrap
);

   // Two guard bits: n = I + sext(M) spans [-2^(AW-1), 2^AW + 2^(AW-1)),
   // and B + L may reach 2^(AW+1) - 2, so both must be compared signed and
   // without aliasing.
   localparam int NW = AW + 2;

   logic [AW-1:0]        i_q, i_d;
   logic [AW-1:0]        b_q, b_d;
   logic [AW-1:0]        l_q, l_d;
   logic signed [AW-1:0] m_q, m_d;
   logic                 wrap_q, wrap_d;
`ifdef DAG_BITREV_EN
   logic                 mode_q, mode_d;
`endif

   logic signed [NW-1:0] n_s, lo_s, hi_s, len_s;
   logic [AW-1:0]        step_val;
   logic                 step_wrap;

   always_comb begin
      b_d = wr_b ? wd : b_q;
      l_d = wr_l ? wd : l_q;
      m_d = wr_m ? signed'(wd) : m_q;
`ifdef DAG_BITREV_EN
      mode_d = wr_mode ? wd[0] : mode_q;
`endif

      n_s   = signed'({2'b00, i_q}) + NW'(m_q);
      lo_s  = signed'({2'b00, b_q});
      len_s = signed'({2'b00, l_q});
      hi_s  = lo_s + len_s;

      // Old B/L/M/MODE are used here, so a same-cycle write to them only
      // affects the following step.
      step_val  = AW'(n_s);
      step_wrap = 1'b0;
      if (l_q != '0) begin
         // Exactly one correction; out-of-range I or |M| >= L is not clamped.
         if (n_s >= hi_s) begin
            step_val  = AW'(n_s - len_s);
            step_wrap = 1'b1;
         end else if (n_s < lo_s) begin
            step_val  = AW'(n_s + len_s);
            step_wrap = 1'b1;
         end
      end
`ifdef DAG_BITREV_EN
      // Reverse-carry add: carries propagate from MSB toward LSB.
      if (mode_q) begin
         step_val  = AW'(bit_rev(64'(AW'(bit_rev(64'(i_q), AW))
                                   + AW'(bit_rev(64'(m_q), AW))), AW));
         step_wrap = 1'b0;
      end
`endif

      // A write to I overrides a simultaneous step, which is then dropped.
      i_d    = i_q;
      wrap_d = 1'b0;
      if (wr_i) begin
         i_d = wd;
      end else if (step) begin
         i_d    = step_val;
         wrap_d = step_wrap;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_q    <= '0;
         b_q    <= '0;
         l_q    <= '0;
         m_q    <= '0;
         wrap_q <= 1'b0;
`ifdef DAG_BITREV_EN
         mode_q <= 1'b0;
`endif
      end else begin
         i_q    <= i_d;
         b_q    <= b_d;
         l_q    <= l_d;
         m_q    <= m_d;
         wrap_q <= wrap_d;
`ifdef DAG_BITREV_EN
         mode_q <= mode_d;
`endif
      end
   end

   assign idx  = i_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/dag_mod.sv
// -----------------------------------------------------------------------------
// dag_mod
// Multi-channel data address generator. Decodes configuration writes to the
// per-channel register files and instantiates NCH dag_channel instances.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   cfg_we   configuration write strobe
//   cfg_ch   target channel (writes to cfg_ch >= NCH are ignored)
//   cfg_sel  register select: 0=I 1=B 2=L 3=M 4=MODE (5-7 ignored)
//   cfg_wd   write data
//   step     per-channel post-modify request
//   addr     packed current I of each channel, channel k at [k*AW +: AW]
//   wrap     per-channel registered wrap pulse
//
// Optional feature macro: DAG_BITREV_EN. When undefined, MODE writes are
// ignored and no reverse-carry logic exists.
// -----------------------------------------------------------------------------
module dag_mod
   import dag_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int NCH = 2,
   parameter int CW  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [CW-1:0]     cfg_ch,
   input  logic [2:0]        cfg_sel,
   input  logic [AW-1:0]     cfg_wd,
   input  logic [NCH-1:0]    step,
   output logic [NCH*AW-1:0] addr,
   output logic [NCH-1:0]    wrap
);

   if ((1 << CW) < NCH) begin : g_bad_cw
      $error("dag_mod: CW too narrow to address NCH channels");
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      // Channel numbers >= NCH match no instance, so those writes vanish.
      logic hit;
      assign hit = cfg_we && (cfg_ch == CW'(k));

      dag_channel #(
         .AW(AW)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr_i    (hit && (cfg_sel == SEL_I)),
         .wr_b    (hit && (cfg_sel == SEL_B)),
         .wr_l    (hit && (cfg_sel == SEL_L)),
         .wr_m    (hit && (cfg_sel == SEL_M)),
`ifdef DAG_BITREV_EN
         .wr_mode (hit && (cfg_sel == SEL_MODE)),
`endif
         .wd      (cfg_wd),
         .step    (step[k]),
         .idx     (addr[k*AW +: AW]),
         .wrap    (wrap[k])
      );
   end

endmodule
